// File: rtl/ariane_axi.sv
// rtl/ariane_axi.sv - AXI channel and bundle types shared by the loader and its responder
package ariane_axi;

  typedef logic [3:0]  id_t;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/reglk_loader.sv
// rtl/reglk_loader.sv - programs register-lock words over AXI-lite with optional read-back verify
module reglk_loader #(
  parameter int unsigned NB_REGS   = 6,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      verify_en_i,
  input  logic [32*NB_REGS-1:0]     lock_vals_i,
  output ariane_axi::req_t          axi_req_o,
  input  ariane_axi::resp_t         axi_resp_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [$clog2(NB_REGS):0]  err_idx_o
);

  // Index width matches err_idx_o; word storage is padded to a power of two
  // so the index selects it without a width mismatch.
  localparam int unsigned IW    = $clog2(NB_REGS) + 1;
  localparam int unsigned NSLOT = 1 << IW;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB_REGS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] err_idx_q;
  logic [TW-1:0] tmo_q;
  logic [31:0]   vals_q   [NSLOT];
  logic [31:0]   in_words [NSLOT];
  logic          verify_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          aw_valid_q;
  logic          w_valid_q;
  logic          aw_done_q;
  logic          w_done_q;
  logic          b_ready_q;
  logic          ar_valid_q;
  logic          r_ready_q;

  // Unpack the flat lock-value bus; padding slots read as zero.
  for (genvar g = 0; g < NSLOT; g++) begin : g_words
    if (g < NB_REGS) begin : g_used
      assign in_words[g] = lock_vals_i[32*g +: 32];
    end else begin : g_pad
      assign in_words[g] = '0;
    end
  end

  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        ar_hs;
  logic        r_hs;
  logic        aw_ok;
  logic        w_ok;
  logic        tmo_hit;
  logic        is_last;
  logic        rd_bad;
  logic [31:0] cur_word;
  logic [63:0] cur_addr;

  assign aw_hs    = aw_valid_q & axi_resp_i.aw_ready;
  assign w_hs     = w_valid_q  & axi_resp_i.w_ready;
  assign b_hs     = b_ready_q  & axi_resp_i.b_valid;
  assign ar_hs    = ar_valid_q & axi_resp_i.ar_ready;
  assign r_hs     = r_ready_q  & axi_resp_i.r_valid;
  assign aw_ok    = aw_done_q | aw_hs;
  assign w_ok     = w_done_q  | w_hs;
  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign is_last  = (idx_q == LAST_IDX);
  assign cur_word = vals_q[idx_q];
  assign cur_addr = BASE_ADDR + {{(61 - IW){1'b0}}, idx_q, 3'b000};
  // A read-locked responder returns zero, which must count as a mismatch
  // against any nonzero programmed word.
  assign rd_bad   = (axi_resp_i.r.resp != RESP_OKAY) ||
                    (axi_resp_i.r.data[31:0] != cur_word);

  // Response fields the loader has no use for.
  logic unused_resp;
  assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.r.id,
                         axi_resp_i.r.data[63:32], axi_resp_i.r.last};

  // Sequencer: one transaction at a time, every AXI valid/ready is a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      err_idx_q  <= '0;
      tmo_q      <= '0;
      verify_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            vals_q     <= in_words;
            verify_q   <= verify_en_i;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b1;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            state_q    <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_ready_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= S_WR_RESP;
          end else if (tmo_hit) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err_q      <= 1'b1;
            err_idx_q  <= idx_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_WR_RESP: begin
          if (b_hs) begin
            b_ready_q <= 1'b0;
            tmo_q     <= '0;
            if (axi_resp_i.b.resp != RESP_OKAY) begin
              err_q     <= 1'b1;
              err_idx_q <= idx_q;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else if (is_last) begin
              if (verify_q) begin
                idx_q      <= '0;
                ar_valid_q <= 1'b1;
                state_q    <= S_RD_REQ;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end else begin
              idx_q      <= idx_q + 1'b1;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= S_WR_REQ;
            end
          end else if (tmo_hit) begin
            b_ready_q <= 1'b0;
            err_q     <= 1'b1;
            err_idx_q <= idx_q;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_RD_REQ: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            tmo_q      <= '0;
            state_q    <= S_RD_RESP;
          end else if (tmo_hit) begin
            ar_valid_q <= 1'b0;
            err_q      <= 1'b1;
            err_idx_q  <= idx_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_RD_RESP: begin
          if (r_hs) begin
            r_ready_q <= 1'b0;
            tmo_q     <= '0;
            if (rd_bad) begin
              err_q     <= 1'b1;
              err_idx_q <= idx_q;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else if (is_last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q      <= idx_q + 1'b1;
              ar_valid_q <= 1'b1;
              state_q    <= S_RD_REQ;
            end
          end else if (tmo_hit) begin
            r_ready_q <= 1'b0;
            err_q     <= 1'b1;
            err_idx_q <= idx_q;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Request bundle: constant single-beat 64-bit attributes around the registered valids.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.addr  = cur_addr;
    axi_req_o.aw.len   = 8'd0;
    axi_req_o.aw.size  = 3'd3;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = {32'h0, cur_word};
    axi_req_o.w.strb   = 8'hFF;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.addr  = cur_addr;
    axi_req_o.ar.len   = 8'd0;
    axi_req_o.ar.size  = 3'd3;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;

endmodule
